// File: rtl/pwm_pkg.sv
// Shared types and elaboration helpers for the multi-channel PWM block.
// No logic: only enums and constant-foldable functions.
package pwm_pkg;

  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_t;

  function automatic int unsigned calc_period(input int unsigned clk_hz,
                                              input int unsigned pwm_hz);
    return clk_hz / pwm_hz;
  endfunction

  function automatic int unsigned idx_w(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // Full-width product before the divide so large duty/period pairs do not overflow.
  function automatic logic [63:0] calc_thr(input logic [31:0]   duty,
                                           input logic [31:0]   period,
                                           input int unsigned   duty_w);
    logic [63:0] prod;
    logic [63:0] dmax;
    prod = {32'd0, duty} * {32'd0, period};
    dmax = (64'd1 << duty_w) - 64'd1;
    return prod / dmax;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM counter: edge (0..P-1) or center (up then down, endpoints held twice).
// period_start is registered (1 cycle after cnt==0 going up); boundary is combinational.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = 10,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             center_mode,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic  dir_down;
  mode_t mode_q;

  assign boundary = en && ((mode_q == MODE_EDGE   && !dir_down && cnt == LAST) ||
                           (mode_q == MODE_CENTER &&  dir_down && cnt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir_down     <= 1'b0;
      mode_q       <= MODE_EDGE;
      period_start <= 1'b0;
    end else if (!en) begin
      // Parked at the start of a period so a restart begins cleanly.
      cnt          <= '0;
      dir_down     <= 1'b0;
      mode_q       <= mode_t'(center_mode);
      period_start <= 1'b0;
    end else begin
      period_start <= (cnt == '0) && !dir_down;
      if (boundary) mode_q <= mode_t'(center_mode);
      if (!dir_down) begin
        if (cnt == LAST) begin
          if (mode_q == MODE_CENTER) dir_down <= 1'b1;
          else                       cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        if (cnt == '0) dir_down <= 1'b0;
        else           cnt      <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with double-buffered duty applied at period boundaries.
// pwm_out lags the counter by 1 cycle; writes are never stalled (last write wins).
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned          CHANNELS = 4,
  parameter int unsigned          DUTY_W   = 8,
  parameter int unsigned          CLK_HZ   = 100000000,
  parameter int unsigned          PWM_HZ   = 1000,
  parameter int unsigned          CNT_W    = 32,
  parameter logic [CHANNELS-1:0]  INVERT   = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  center_mode,
  input  logic                                  wr_en,
  input  logic [idx_w(CHANNELS)-1:0]            wr_ch,
  input  logic [DUTY_W-1:0]                     wr_duty,
  output logic [CHANNELS-1:0]                   pwm_out,
  output logic                                  period_start,
  output logic                                  upd_pending
);

  localparam int unsigned PERIOD = calc_period(CLK_HZ, PWM_HZ);
  localparam int unsigned CH_W   = idx_w(CHANNELS);

  if (PERIOD < 2) begin : g_bad_period
    $error("pwm_multi_ch: CLK_HZ/PWM_HZ must be at least 2");
  end
  if ($clog2(PERIOD + 1) > CNT_W) begin : g_bad_cnt_w
    $error("pwm_multi_ch: CNT_W too narrow for PERIOD");
  end

  logic [CNT_W-1:0]    cnt;
  logic                boundary;
  logic                wr_ok;
  logic [CNT_W-1:0]    wr_thr;
  logic [CHANNELS-1:0] pend_d;

  pwm_timebase #(.PERIOD(PERIOD), .CNT_W(CNT_W)) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .center_mode  (center_mode),
    .cnt          (cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  // Divide happens on the write path only; the comparator sees a plain register.
  assign wr_ok  = wr_en && (32'(wr_ch) < CHANNELS);
  assign wr_thr = CNT_W'(calc_thr(32'(wr_duty), PERIOD, DUTY_W));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] stage_q;
    logic [CNT_W-1:0] active_q;
    logic             pend_q;
    logic             out_q;
    logic             wr_sel;
    logic             pend_nxt;

    assign wr_sel   = wr_ok && (wr_ch == CH_W'(i));
    // A write landing on the boundary re-arms pending rather than being consumed.
    assign pend_nxt = wr_sel | (pend_q & en & ~boundary);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q  <= '0;
        active_q <= '0;
        pend_q   <= 1'b0;
        out_q    <= INVERT[i];
      end else begin
        if (wr_sel) stage_q <= wr_thr;
        if (!en || (boundary && pend_q)) active_q <= stage_q;
        pend_q <= pend_nxt;
        out_q  <= en ? ((cnt < active_q) ^ INVERT[i]) : INVERT[i];
      end
    end

    assign pend_d[i]  = pend_nxt;
    assign pwm_out[i] = out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_pending <= 1'b0;
    else        upd_pending <= |pend_d;
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch with PERIOD=10 and channel 0 inverted.
module tb_pwm_multi_ch;

  localparam logic [3:0] INV = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       center_mode;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_duty;
  logic [3:0] pwm_out;
  logic       period_start;
  logic       upd_pending;

  int errors = 0;
  int checks = 0;

  logic [39:0] pat [4];
  logic [39:0] ps_pat;
  logic [39:0] up_pat;

  typedef struct {
    int         ch;
    logic [7:0] duty;
    int         thr;
  } vec_t;
  vec_t vecs [8];

  pwm_multi_ch #(
    .CHANNELS (4),
    .DUTY_W   (8),
    .CLK_HZ   (1000),
    .PWM_HZ   (100),
    .CNT_W    (32),
    .INVERT   (INV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .center_mode  (center_mode),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .upd_pending  (upd_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ps();
    int b = 0;
    step();
    while (!period_start && b < 50) begin
      step();
      b++;
    end
    checks++;
    if (!period_start) begin
      errors++;
      $display("FAIL wait_ps: got no period_start expected one within 50 cycles");
    end
  endtask

  task automatic write1(input logic [1:0] c, input logic [7:0] d);
    wr_en = 1'b1; wr_ch = c; wr_duty = d;
    step();
    wr_en = 1'b0;
  endtask

  // Sample j holds the pin value derived from counter position j of the window.
  task automatic capture(input int n, input int wr_at, input logic [1:0] c, input logic [7:0] d);
    for (int k = 0; k < 4; k++) pat[k] = '0;
    ps_pat = '0;
    up_pat = '0;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 4; k++) pat[k][j] = pwm_out[k] ^ INV[k];
      ps_pat[j] = period_start;
      up_pat[j] = upd_pending;
      if (j == wr_at) begin
        wr_en = 1'b1; wr_ch = c; wr_duty = d;
      end else begin
        wr_en = 1'b0;
      end
      if (j < n - 1) step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2, 8'd0,   0};
    vecs[1] = '{3, 8'd25,  0};
    vecs[2] = '{2, 8'd26,  1};
    vecs[3] = '{3, 8'd100, 3};
    vecs[4] = '{2, 8'd128, 5};
    vecs[5] = '{3, 8'd204, 8};
    vecs[6] = '{2, 8'd254, 9};
    vecs[7] = '{3, 8'd255, 10};

    rst_n = 1'b1; en = 1'b0; center_mode = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("reset_pwm", 40'(pwm_out), 40'(INV));
    chk("reset_ps", 40'(period_start), 40'd0);
    chk("reset_upd", 40'(upd_pending), 40'd0);

    // Basic duties on three channels
    rst_n = 1'b1; en = 1'b1;
    write1(2'd0, 8'd128);
    write1(2'd1, 8'd255);
    write1(2'd2, 8'd0);
    chk("t1_upd_after_wr", 40'(upd_pending), 40'd1);
    wait_ps(); wait_ps();
    capture(10, -1, 2'd0, 8'd0);
    chk("t1_ch0", pat[0], 40'h1F);
    chk("t1_ch1", pat[1], 40'h3FF);
    chk("t1_ch2", pat[2], 40'h0);
    chk("t1_ch3", pat[3], 40'h0);
    chk("t1_ps", ps_pat, 40'h001);

    // Mid-period update is held to the next boundary
    wait_ps();
    capture(20, 3, 2'd0, 8'd51);
    chk("t2_ch0", pat[0], 40'h00C1F);
    chk("t2_upd", up_pat, 40'h001F0);
    chk("t2_ps", ps_pat, 40'h00401);

    // Write on the boundary cycle waits one extra period
    wait_ps();
    capture(30, 8, 2'd0, 8'd128);
    chk("t3_ch0", pat[0], 40'h001F00C03);
    chk("t3_upd", up_pat, 40'h00007FE00);

    // Center-aligned
    center_mode = 1'b1;
    wait_ps(); wait_ps();
    capture(40, -1, 2'd0, 8'd0);
    chk("t4_ch0", pat[0], 40'hF801FF801F);
    chk("t4_ps", ps_pat, 40'h0000100001);
    center_mode = 1'b0;
    wait_ps(); wait_ps();

    // Enable dropped for three cycles mid-period
    repeat (3) step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_off_pwm", 40'(pwm_out), 40'(INV));
      chk("t5_off_ps", 40'(period_start), 40'd0);
    end
    en = 1'b1;
    step();
    chk("t5_restart_ps", 40'(period_start), 40'd1);
    chk("t5_restart_pwm", 40'(pwm_out), 40'h2);
    capture(10, -1, 2'd0, 8'd0);
    chk("t5_ch0", pat[0], 40'h1F);
    chk("t5_ps", ps_pat, 40'h001);

    // Duty sweep through the threshold rounding points
    foreach (vecs[v]) begin
      write1(2'(vecs[v].ch), vecs[v].duty);
      wait_ps(); wait_ps();
      capture(10, -1, 2'd0, 8'd0);
      chk($sformatf("sweep_ch%0d_d%0d", vecs[v].ch, vecs[v].duty),
          pat[vecs[v].ch], (40'd1 << vecs[v].thr) - 40'd1);
      chk("sweep_ps", ps_pat, 40'h001);
    end

    // Back-to-back writes: last one wins
    write1(2'd3, 8'd255);
    write1(2'd3, 8'd51);
    wait_ps(); wait_ps();
    capture(10, -1, 2'd0, 8'd0);
    chk("b2b_ch3", pat[3], 40'h3);

    // Asynchronous reset with a write pending
    write1(2'd0, 8'd26);
    chk("t6_upd_before", 40'(upd_pending), 40'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_pwm", 40'(pwm_out), 40'(INV));
    chk("t6_async_upd", 40'(upd_pending), 40'd0);
    chk("t6_async_ps", 40'(period_start), 40'd0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_ps(); wait_ps();
    capture(10, -1, 2'd0, 8'd0);
    chk("t6_ch0_cleared", pat[0], 40'h0);
    chk("t6_ch1_cleared", pat[1], 40'h0);
    chk("t6_ps", ps_pat, 40'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
- Multi-channel PWM generator. One shared timebase drives CHANNELS independent comparators.
- Supports edge-aligned and center-aligned modes, per-channel output inversion and a global enable.
- Duty updates are double-buffered and take effect only at a period boundary, so outputs never glitch.
- Drives motor/LED/audio PWM pins from the 100 MHz system clock; software writes duty through a simple write strobe.

Parameters:
- CHANNELS, 4: number of PWM outputs (1..16).
- DUTY_W, 8: duty code width. Code 0 = 0 %, code 2^DUTY_W-1 = 100 %.
- CLK_HZ, 100000000: system clock frequency.
- PWM_HZ, 1000: edge-mode PWM frequency. PERIOD = CLK_HZ/PWM_HZ (integer division). PERIOD >= 2 is required; elaboration-time error otherwise.
- CNT_W, 32: timebase counter width. Must hold PERIOD.
- INVERT, {CHANNELS{1'b0}}: per-channel output inversion mask.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: global run enable.
- center_mode, in, 1: 0 = edge-aligned, 1 = center-aligned. Sampled at period boundary.
- wr_en, in, 1: one-cycle duty write strobe.
- wr_ch, in, max(1,$clog2(CHANNELS)): channel index for the write.
- wr_duty, in, DUTY_W: duty code for the write.
- pwm_out, out, CHANNELS: PWM outputs, registered.
- period_start, out, 1: one-cycle pulse at counter 0 at the start of each period.
- upd_pending, out, 1: high while any staged write is not yet applied.

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, dir=up, mode=edge.
  - All staged and active thresholds = 0.
  - pwm_out = INVERT; period_start = 0; upd_pending = 0.
- Threshold: thr = (duty*PERIOD)/(2^DUTY_W-1), computed at full width (DUTY_W+CNT_W) and truncated. It is computed and registered into the staging register on the write cycle, so there is no combinational divide in the comparator path.
- Write: when wr_en=1 and wr_ch<CHANNELS, stage[wr_ch] <= thr(wr_duty) and pending[wr_ch] <= 1.
  - wr_ch >= CHANNELS: write ignored.
  - Back-to-back writes to the same channel: last write wins.
- Edge mode: cnt counts 0..PERIOD-1 and wraps to 0. Period = PERIOD cycles.
- Center mode: cnt counts up 0..PERIOD-1, then down PERIOD-1..0. Each endpoint is held 2 cycles. Period = 2*PERIOD cycles and the pulse is symmetric.
- Boundary cycle: the last cycle of a period (edge: cnt==PERIOD-1; center: cnt==0 with dir=down). On the boundary cycle:
  - active <= stage for every pending channel;
  - pending is cleared;
  - mode <= center_mode.
  - A write in the boundary cycle itself is NOT applied by that boundary; it stays pending until the next one.
- Output: pwm_out[i](t+1) = (cnt(t) < active_thr[i]) XOR INVERT[i]. Latency is 1 cycle from counter to pin.
  - thr=0 gives constant inactive; thr=PERIOD gives constant active.
- period_start(t+1) = 1 when en=1 and cnt(t) is the first cycle of a period (cnt==0 with dir=up).
- en=0:
  - next cycle: cnt=0, dir=up, pwm_out=INVERT, period_start=0.
  - Staged values are copied to active each cycle and mode tracks center_mode, so restart uses the latest settings.
  - When en rises, the first period starts at cnt=0 and period_start pulses 1 cycle later.
- Reset mid-period: all state is discarded immediately; pending writes are lost.
- upd_pending = OR of the pending bits, registered.

Decomposition:
- pwm_pkg:
  - mode_t enum {MODE_EDGE, MODE_CENTER};
  - function calc_thr(duty, period);
  - localparam helpers for PERIOD and channel index width.
- Sub-module pwm_timebase: owns cnt, dir, mode latch, boundary and period_start generation. Shared by all channels.
- Per-channel staging, active and compare logic lives in a generate loop in pwm_multi_ch.

Test Plan (CHANNELS=4, DUTY_W=8, CLK_HZ=1000, PWM_HZ=100, so PERIOD=10):
1. Reset, en=1, write ch0=128, ch1=255, ch2=0 -> from the second period: ch0 high 5 of 10 cycles (thr=5), ch1 constant 1, ch2 constant 0, ch3 constant 0; period_start every 10 cycles.
2. Write ch0=51 mid-period while ch0=128 is active -> current period keeps 5 high cycles; next period has 2 high cycles; upd_pending is high from the write until the boundary.
3. Write issued exactly on the boundary cycle (cnt==9) -> not applied at that boundary; applied one period later.
4. center_mode=1, ch0=128 -> period 20 cycles, ch0 high for cnt<5 on both slopes (10 high cycles centred on cnt=0); period_start every 20 cycles.
5. INVERT=4'b0001, en toggled low for 3 cycles mid-period -> pwm_out=4'b0001 the cycle after en falls; after en rises, cnt restarts at 0 and period_start pulses once.
6. Assert rst_n low asynchronously mid-period with writes pending -> pwm_out=INVERT and upd_pending=0 without waiting for a clock edge; staged duties are cleared.
